// File: rtl/fb_pkg.sv
// Shared framebuffer definitions used by the write master and the scan-out reader.
//  - FB_ADDR_W / FB_DATA_W / FB_BE_W : 29-bit word address, 64-bit data, 8 byte enables
//  - FB_BUFFER0_BASE / FB_BUFFER1_BASE : word addresses of the two frame buffers
//  - fb_beat_t  : one 64-bit SDRAM word plus its byte enables
//  - pack_pixel : place a 32-bit pixel into the low or high half of an empty word
//  - merge_pixel: overlay a 32-bit pixel onto an existing word (later pixel wins)
package fb_pkg;

  localparam int FB_ADDR_W = 29;
  localparam int FB_DATA_W = 64;
  localparam int FB_BE_W   = 8;

  localparam logic [FB_ADDR_W-1:0] FB_BUFFER0_BASE = 29'h0800000;
  localparam logic [FB_ADDR_W-1:0] FB_BUFFER1_BASE = 29'h0840000;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_BURST   = 1'b1
  } fb_state_t;

  typedef struct packed {
    logic [FB_DATA_W-1:0] data;
    logic [FB_BE_W-1:0]   be;
  } fb_beat_t;

  // Even pixel index -> low half, odd pixel index -> high half.
  function automatic fb_beat_t pack_pixel(input logic [31:0] color, input logic hi);
    fb_beat_t beat;
    if (hi) begin
      beat.data = {color, 32'h0000_0000};
      beat.be   = 8'hF0;
    end else begin
      beat.data = {32'h0000_0000, color};
      beat.be   = 8'h0F;
    end
    return beat;
  endfunction

  function automatic fb_beat_t merge_pixel(input fb_beat_t old, input logic [31:0] color,
                                           input logic hi);
    fb_beat_t beat;
    beat = old;
    if (hi) begin
      beat.data[63:32] = color;
      beat.be          = old.be | 8'hF0;
    end else begin
      beat.data[31:0]  = color;
      beat.be          = old.be | 8'h0F;
    end
    return beat;
  endfunction

endpackage

// File: rtl/fb_burst_buffer.sv
// Burst staging buffer: DEPTH entries of {64-bit data, 8-bit byte enable}.
//  clock, reset : clock and synchronous active-high reset (clears every entry)
//  wr_en        : write strobe for entry wr_idx
//  wr_init      : 1 -> entry starts fresh with this pixel, 0 -> pixel merged into entry
//  wr_idx       : entry to write
//  wr_color     : 32-bit pixel colour
//  wr_hi        : pixel goes to data[63:32] (1) or data[31:0] (0)
//  rd_idx       : beat index being presented on the bus
//  rd_data/rd_be: contents of entry rd_idx
module fb_burst_buffer
  import fb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic                 wr_init,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [31:0]          wr_color,
  input  logic                 wr_hi,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [FB_DATA_W-1:0] rd_data,
  output logic [FB_BE_W-1:0]   rd_be
);

  fb_beat_t [DEPTH-1:0] entry_q;
  fb_beat_t             fresh_beat;

  assign fresh_beat = pack_pixel(wr_color, wr_hi);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    fb_beat_t entry_reg;

    always_ff @(posedge clock) begin
      if (reset) begin
        entry_reg <= '0;
      end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
        entry_reg <= wr_init ? fresh_beat : merge_pixel(entry_reg, wr_color, wr_hi);
      end
    end

    assign entry_q[gi] = entry_reg;
  end

  assign rd_data = entry_q[rd_idx].data;
  assign rd_be   = entry_q[rd_idx].be;

endmodule

// File: rtl/framebuffer_write.sv
// Avalon-MM burst write master for the frame back buffer.
// Packs the rasteriser's (x, y, colour) stream into 64-bit words, coalesces runs of
// consecutive words into bursts (never crossing a MAX_BURST-aligned boundary) and
// writes them through the f2h_sdram port.
//  clock, reset          : clock, synchronous active-high reset
//  pix_valid/pix_ready   : pixel handshake; pix_x, pix_y, pix_color carry the pixel
//  buffer                : target buffer select (0 -> BUFFER0_BASE, 1 -> BUFFER1_BASE)
//  flush                 : while high, an open burst is issued immediately
//  idle                  : nothing open, nothing held, nothing in flight
//  address, burstcount, writedata, byteenable, write, waitrequest : Avalon-MM master
module framebuffer_write
  import fb_pkg::*;
#(
  parameter int                     FB_WIDTH     = 640,
  parameter int                     FB_HEIGHT    = 480,
  parameter logic [FB_ADDR_W-1:0]   BUFFER0_BASE = FB_BUFFER0_BASE,
  parameter logic [FB_ADDR_W-1:0]   BUFFER1_BASE = FB_BUFFER1_BASE,
  parameter int                     MAX_BURST    = 16,
  parameter int                     IDLE_TIMEOUT = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [10:0]          pix_x,
  input  logic [10:0]          pix_y,
  input  logic [31:0]          pix_color,
  input  logic                 buffer,
  input  logic                 flush,
  output logic                 idle,
  output logic [FB_ADDR_W-1:0] address,
  output logic [7:0]           burstcount,
  output logic [FB_DATA_W-1:0] writedata,
  output logic [FB_BE_W-1:0]   byteenable,
  output logic                 write,
  input  logic                 waitrequest
);

  localparam int                   IDX_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [FB_ADDR_W-1:0] ALIGN_MASK = FB_ADDR_W'(MAX_BURST - 1);
  localparam logic [7:0]           MAX_COUNT  = 8'(MAX_BURST);
  localparam logic [15:0]          TMO_LIMIT  = 16'(IDLE_TIMEOUT);

  fb_state_t state_reg, state_next;

  logic [7:0]           count_reg;
  logic [FB_ADDR_W-1:0] first_reg;
  logic [FB_ADDR_W-1:0] last_reg;
  logic [IDX_W-1:0]     beat_reg;
  logic [15:0]          tmo_reg;
  logic                 hold_valid_reg;
  logic [FB_ADDR_W-1:0] hold_addr_reg;
  logic [31:0]          hold_color_reg;
  logic                 hold_hi_reg;

  // Pixel address decode
  logic [FB_ADDR_W-1:0] pidx;
  logic [FB_ADDR_W-1:0] waddr;
  logic                 pix_hi;
  logic                 in_range;
  logic                 accept;

  assign pidx     = FB_ADDR_W'(pix_y) * FB_ADDR_W'(FB_WIDTH) + FB_ADDR_W'(pix_x);
  assign pix_hi   = pidx[0];
  assign waddr    = (buffer ? BUFFER1_BASE : BUFFER0_BASE) + (pidx >> 1);
  assign in_range = (int'(pix_x) < FB_WIDTH) && (int'(pix_y) < FB_HEIGHT);
  assign accept   = pix_valid && pix_ready;

  // Classify an accepted in-range pixel against the open burst.
  logic do_new, do_merge, do_append, do_hold;

  always_comb begin
    do_new    = 1'b0;
    do_merge  = 1'b0;
    do_append = 1'b0;
    do_hold   = 1'b0;
    if (accept && in_range) begin
      if (count_reg == 8'd0) begin
        do_new = 1'b1;
      end else if (waddr == last_reg) begin
        do_merge = 1'b1;
      end else if ((waddr == last_reg + FB_ADDR_W'(1)) && (count_reg < MAX_COUNT) &&
                   ((waddr & ALIGN_MASK) != '0)) begin
        do_append = 1'b1;
      end else begin
        do_hold = 1'b1;
      end
    end
  end

  logic tmo_hit, burst_close, last_beat;

  assign tmo_hit = (tmo_reg == TMO_LIMIT);
  // The incoming pixel is folded in before the close decision, so a first pixel
  // arriving together with flush still produces a one-beat burst.
  assign burst_close = (state_reg == ST_COLLECT) && ((count_reg != 8'd0) || do_new) &&
                       (do_hold || flush || tmo_hit);
  assign last_beat   = (state_reg == ST_BURST) && !waitrequest &&
                       (8'(beat_reg) == count_reg - 8'd1);

  // Burst buffer write port: hold-register reload at burst end, otherwise the pixel.
  logic             wr_en, wr_init, wr_hi;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_color;
  logic [FB_DATA_W-1:0] rd_data;
  logic [FB_BE_W-1:0]   rd_be;

  always_comb begin
    wr_en    = 1'b0;
    wr_init  = 1'b0;
    wr_idx   = '0;
    wr_color = pix_color;
    wr_hi    = pix_hi;
    if (last_beat && hold_valid_reg) begin
      wr_en    = 1'b1;
      wr_init  = 1'b1;
      wr_color = hold_color_reg;
      wr_hi    = hold_hi_reg;
    end else if (do_new) begin
      wr_en   = 1'b1;
      wr_init = 1'b1;
    end else if (do_merge) begin
      wr_en  = 1'b1;
      wr_idx = IDX_W'(count_reg - 8'd1);
    end else if (do_append) begin
      wr_en   = 1'b1;
      wr_init = 1'b1;
      wr_idx  = IDX_W'(count_reg);
    end
  end

  fb_burst_buffer #(
    .DEPTH (MAX_BURST),
    .IDX_W (IDX_W)
  ) u_burst_buffer (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_init  (wr_init),
    .wr_idx   (wr_idx),
    .wr_color (wr_color),
    .wr_hi    (wr_hi),
    .rd_idx   (beat_reg),
    .rd_data  (rd_data),
    .rd_be    (rd_be)
  );

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_COLLECT) begin
      if (burst_close) state_next = ST_BURST;
    end else begin
      if (last_beat) state_next = ST_COLLECT;
    end
  end

  // FSM: outputs. Everything on the bus comes from registers, so it holds under stall.
  always_comb begin
    write      = 1'b0;
    address    = '0;
    burstcount = '0;
    writedata  = '0;
    byteenable = '0;
    pix_ready  = 1'b0;
    idle       = 1'b0;
    if (state_reg == ST_BURST) begin
      write      = 1'b1;
      address    = first_reg;
      burstcount = count_reg;
      writedata  = rd_data;
      byteenable = rd_be;
    end else begin
      pix_ready = !hold_valid_reg;
      idle      = (count_reg == 8'd0) && !hold_valid_reg;
    end
  end

  // Burst bookkeeping, hold register and idle timeout
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg      <= '0;
      first_reg      <= '0;
      last_reg       <= '0;
      beat_reg       <= '0;
      tmo_reg        <= '0;
      hold_valid_reg <= 1'b0;
      hold_addr_reg  <= '0;
      hold_color_reg <= '0;
      hold_hi_reg    <= 1'b0;
    end else if (state_reg == ST_COLLECT) begin
      beat_reg <= '0;
      if (do_new) begin
        first_reg <= waddr;
        last_reg  <= waddr;
        count_reg <= 8'd1;
      end else if (do_append) begin
        last_reg  <= waddr;
        count_reg <= count_reg + 8'd1;
      end
      if (do_hold) begin
        hold_valid_reg <= 1'b1;
        hold_addr_reg  <= waddr;
        hold_color_reg <= pix_color;
        hold_hi_reg    <= pix_hi;
      end
      // Counts only while something is open; saturates at the limit.
      if (accept || burst_close) begin
        tmo_reg <= '0;
      end else if ((count_reg != 8'd0) && !tmo_hit) begin
        tmo_reg <= tmo_reg + 16'd1;
      end
    end else begin
      if (last_beat) begin
        beat_reg <= '0;
        if (hold_valid_reg) begin
          first_reg      <= hold_addr_reg;
          last_reg       <= hold_addr_reg;
          count_reg      <= 8'd1;
          hold_valid_reg <= 1'b0;
        end else begin
          count_reg <= '0;
        end
      end else if (!waitrequest) begin
        beat_reg <= beat_reg + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_write.sv
// Directed testbench for framebuffer_write.
module tb_framebuffer_write;

  localparam logic [28:0] B0 = 29'h0800000;
  localparam logic [28:0] B1 = 29'h0840000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [10:0] pix_x = '0;
  logic [10:0] pix_y = '0;
  logic [31:0] pix_color = '0;
  logic        buffer = 1'b0;
  logic        flush = 1'b0;
  logic        idle;
  logic [28:0] address;
  logic [7:0]  burstcount;
  logic [63:0] writedata;
  logic [7:0]  byteenable;
  logic        write;
  logic        waitrequest = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Captured burst
  logic [63:0] cap_data [16];
  logic [7:0]  cap_be   [16];
  int          cap_n;
  logic [28:0] cap_addr;
  logic [7:0]  cap_bc;
  bit          cap_ok;
  int          cap_stall_bad;
  logic        cap_write_after;

  framebuffer_write dut (
    .clock       (clock),
    .reset       (reset),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_color   (pix_color),
    .buffer      (buffer),
    .flush       (flush),
    .idle        (idle),
    .address     (address),
    .burstcount  (burstcount),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .write       (write),
    .waitrequest (waitrequest)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_pixel(input int x, input int y, input logic [31:0] c, input logic b);
    int guard = 0;
    pix_valid = 1'b1;
    pix_x     = 11'(x);
    pix_y     = 11'(y);
    pix_color = c;
    buffer    = b;
    while (pix_ready !== 1'b1 && guard < 500) begin
      tick();
      guard++;
    end
    tick();
    pix_valid = 1'b0;
  endtask

  // Records one burst; with rand_wait the slave stalls about half the cycles and
  // any change of the bus outputs across a stalled edge is counted.
  task automatic capture_burst(input bit rand_wait);
    int guard = 0;
    bit stall;
    logic [28:0] a0;
    logic [7:0]  bc0, b0;
    logic [63:0] d0;
    cap_ok = 0;
    cap_n = 0;
    cap_stall_bad = 0;
    cap_addr = '0;
    cap_bc = '0;
    while (write !== 1'b1 && guard < 300) begin
      tick();
      guard++;
    end
    if (write !== 1'b1) return;
    cap_addr = address;
    cap_bc   = burstcount;
    guard = 0;
    while (cap_n < int'(cap_bc) && cap_n < 16 && guard < 300) begin
      stall = rand_wait ? ($urandom_range(0, 1) == 1) : 1'b0;
      waitrequest = stall;
      a0 = address; bc0 = burstcount; d0 = writedata; b0 = byteenable;
      tick();
      guard++;
      if (!stall) begin
        cap_data[cap_n] = d0;
        cap_be[cap_n]   = b0;
        cap_n++;
      end else if (write !== 1'b1 || address !== a0 || burstcount !== bc0 ||
                   writedata !== d0 || byteenable !== b0) begin
        cap_stall_bad++;
      end
      if (cap_n < int'(cap_bc) && (write !== 1'b1 || address !== cap_addr ||
                                   burstcount !== cap_bc)) begin
        cap_stall_bad++;
      end
    end
    waitrequest = 1'b0;
    cap_ok = (cap_n == int'(cap_bc)) && (guard < 300);
    cap_write_after = write;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %0b expected 0", write); end
    n_checks++; if (address !== 29'h0) begin n_fail++; $display("FAIL reset_address: got %h expected 0", address); end
    n_checks++; if (burstcount !== 8'h0) begin n_fail++; $display("FAIL reset_burstcount: got %0d expected 0", burstcount); end
    n_checks++; if (writedata !== 64'h0) begin n_fail++; $display("FAIL reset_writedata: got %h expected 0", writedata); end
    n_checks++; if (byteenable !== 8'h0) begin n_fail++; $display("FAIL reset_byteenable: got %h expected 0", byteenable); end
    reset = 1'b0;
    tick();
    n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL reset_pix_ready: got %0b expected 1", pix_ready); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %0b expected 1", idle); end
    $display("test_reset done");
  endtask

  task automatic test_merge();
    send_pixel(0, 0, 32'h11223344, 1'b0);
    send_pixel(1, 0, 32'h55667788, 1'b0);
    flush = 1'b1;
    capture_burst(1'b0);
    flush = 1'b0;
    n_checks++; if (cap_ok !== 1'b1) begin n_fail++; $display("FAIL merge_complete: got %0d beats expected 1", cap_n); end
    n_checks++; if (cap_addr !== B0) begin n_fail++; $display("FAIL merge_addr: got %h expected %h", cap_addr, B0); end
    n_checks++; if (cap_bc !== 8'd1) begin n_fail++; $display("FAIL merge_burstcount: got %0d expected 1", cap_bc); end
    n_checks++; if (cap_data[0] !== 64'h55667788_11223344) begin n_fail++; $display("FAIL merge_data: got %h expected 5566778811223344", cap_data[0]); end
    n_checks++; if (cap_be[0] !== 8'hFF) begin n_fail++; $display("FAIL merge_be: got %h expected ff", cap_be[0]); end
    n_checks++; if (cap_write_after !== 1'b0) begin n_fail++; $display("FAIL merge_write_drop: got %0b expected 0", cap_write_after); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL merge_idle: got %0b expected 1", idle); end
    $display("test_merge: addr=%h bc=%0d data=%h be=%h", cap_addr, cap_bc, cap_data[0], cap_be[0]);
  endtask

  task automatic test_burst_stall();
    int bad_d = 0, bad_b = 0;
    logic [31:0] lo, hi;
    for (int x = 0; x < 32; x++) send_pixel(x, 0, 32'h00A00000 + 32'(x), 1'b0);
    flush = 1'b1;
    capture_burst(1'b1);
    flush = 1'b0;
    for (int i = 0; i < 16; i++) begin
      lo = 32'h00A00000 + 32'(2 * i);
      hi = 32'h00A00000 + 32'(2 * i + 1);
      if (cap_data[i] !== {hi, lo}) bad_d++;
      if (cap_be[i] !== 8'hFF) bad_b++;
    end
    n_checks++; if (cap_ok !== 1'b1) begin n_fail++; $display("FAIL burst16_complete: got %0d beats expected 16", cap_n); end
    n_checks++; if (cap_bc !== 8'd16) begin n_fail++; $display("FAIL burst16_burstcount: got %0d expected 16", cap_bc); end
    n_checks++; if (cap_addr !== B0) begin n_fail++; $display("FAIL burst16_addr: got %h expected %h", cap_addr, B0); end
    n_checks++; if (bad_d != 0) begin n_fail++; $display("FAIL burst16_data: got %0d wrong beats expected 0", bad_d); end
    n_checks++; if (bad_b != 0) begin n_fail++; $display("FAIL burst16_be: got %0d wrong enables expected 0", bad_b); end
    n_checks++; if (cap_stall_bad != 0) begin n_fail++; $display("FAIL burst16_stall_stable: got %0d changes expected 0", cap_stall_bad); end
    $display("test_burst_stall: addr=%h bc=%0d beats=%0d", cap_addr, cap_bc, cap_n);
  endtask

  task automatic test_two_bursts();
    fork
      begin
        send_pixel(0, 0, 32'h00010203, 1'b0);
        send_pixel(10, 5, 32'h00040506, 1'b0);
        flush = 1'b1;
      end
      begin
        capture_burst(1'b0);
        n_checks++; if (cap_addr !== B0 || cap_bc !== 8'd1 || cap_ok !== 1'b1) begin n_fail++; $display("FAIL two_first_hdr: got addr %h bc %0d expected %h bc 1", cap_addr, cap_bc, B0); end
        n_checks++; if (cap_data[0] !== 64'h00000000_00010203) begin n_fail++; $display("FAIL two_first_data: got %h expected 0000000000010203", cap_data[0]); end
        n_checks++; if (cap_be[0] !== 8'h0F) begin n_fail++; $display("FAIL two_first_be: got %h expected 0f", cap_be[0]); end
        $display("test_two_bursts first: addr=%h bc=%0d", cap_addr, cap_bc);
        capture_burst(1'b0);
        n_checks++; if (cap_addr !== B0 + 29'd1605) begin n_fail++; $display("FAIL two_second_addr: got %h expected %h", cap_addr, B0 + 29'd1605); end
        n_checks++; if (cap_bc !== 8'd1 || cap_ok !== 1'b1) begin n_fail++; $display("FAIL two_second_bc: got %0d expected 1", cap_bc); end
        n_checks++; if (cap_be[0] !== 8'h0F) begin n_fail++; $display("FAIL two_second_be: got %h expected 0f", cap_be[0]); end
        n_checks++; if (cap_data[0] !== 64'h00000000_00040506) begin n_fail++; $display("FAIL two_second_data: got %h expected 0000000000040506", cap_data[0]); end
        $display("test_two_bursts second: addr=%h bc=%0d", cap_addr, cap_bc);
      end
    join
    flush = 1'b0;
  endtask

  task automatic test_align_split();
    fork
      begin
        for (int x = 28; x < 36; x++) send_pixel(x, 0, 32'h00C00000 + 32'(x), 1'b0);
        flush = 1'b1;
      end
      begin
        capture_burst(1'b0);
        n_checks++; if (cap_addr !== B0 + 29'd14) begin n_fail++; $display("FAIL align_first_addr: got %h expected %h", cap_addr, B0 + 29'd14); end
        n_checks++; if (cap_bc !== 8'd2 || cap_ok !== 1'b1) begin n_fail++; $display("FAIL align_first_bc: got %0d expected 2", cap_bc); end
        n_checks++; if (cap_data[0] !== 64'h00C0001D_00C0001C || cap_data[1] !== 64'h00C0001F_00C0001E) begin n_fail++; $display("FAIL align_first_data: got %h %h expected 00c0001d00c0001c 00c0001f00c0001e", cap_data[0], cap_data[1]); end
        $display("test_align_split first: addr=%h bc=%0d", cap_addr, cap_bc);
        capture_burst(1'b0);
        n_checks++; if (cap_addr !== B0 + 29'd16) begin n_fail++; $display("FAIL align_second_addr: got %h expected %h", cap_addr, B0 + 29'd16); end
        n_checks++; if (cap_bc !== 8'd2 || cap_ok !== 1'b1) begin n_fail++; $display("FAIL align_second_bc: got %0d expected 2", cap_bc); end
        n_checks++; if (cap_data[0] !== 64'h00C00021_00C00020 || cap_data[1] !== 64'h00C00023_00C00022) begin n_fail++; $display("FAIL align_second_data: got %h %h expected 00c0002100c00020 00c0002300c00022", cap_data[0], cap_data[1]); end
        n_checks++; if (cap_be[0] !== 8'hFF || cap_be[1] !== 8'hFF) begin n_fail++; $display("FAIL align_second_be: got %h %h expected ff ff", cap_be[0], cap_be[1]); end
        $display("test_align_split second: addr=%h bc=%0d", cap_addr, cap_bc);
      end
    join
    flush = 1'b0;
  endtask

  task automatic test_timeout();
    int n = 0;
    int writes = 0;
    send_pixel(3, 0, 32'h00ABCDEF, 1'b1);
    while (write !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    n_checks++; if (n != 65) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles expected 65", n); end
    capture_burst(1'b0);
    n_checks++; if (cap_addr !== B1 + 29'd1) begin n_fail++; $display("FAIL timeout_addr: got %h expected %h", cap_addr, B1 + 29'd1); end
    n_checks++; if (cap_bc !== 8'd1 || cap_ok !== 1'b1) begin n_fail++; $display("FAIL timeout_bc: got %0d expected 1", cap_bc); end
    n_checks++; if (cap_be[0] !== 8'hF0) begin n_fail++; $display("FAIL timeout_be: got %h expected f0", cap_be[0]); end
    n_checks++; if (cap_data[0] !== 64'h00ABCDEF_00000000) begin n_fail++; $display("FAIL timeout_data: got %h expected 00abcdef00000000", cap_data[0]); end
    $display("test_timeout: latency=%0d addr=%h be=%h", n, cap_addr, cap_be[0]);
    send_pixel(640, 0, 32'h00FFFFFF, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (write === 1'b1) writes++;
      tick();
    end
    n_checks++; if (writes != 0) begin n_fail++; $display("FAIL offscreen_write: got %0d write cycles expected 0", writes); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL offscreen_idle: got %0b expected 1", idle); end
    $display("test_offscreen: write cycles=%0d", writes);
  endtask

  task automatic test_reset_mid_burst();
    int guard = 0;
    for (int x = 0; x < 32; x++) send_pixel(x, 2, 32'h00500000 + 32'(x), 1'b0);
    flush = 1'b1;
    while (write !== 1'b1 && guard < 300) begin
      tick();
      guard++;
    end
    n_checks++; if (write !== 1'b1) begin n_fail++; $display("FAIL midreset_start: got write %0b expected 1", write); end
    repeat (3) tick();
    reset = 1'b1;
    flush = 1'b0;
    tick();
    n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL midreset_write: got %0b expected 0", write); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL midreset_idle: got %0b expected 1", idle); end
    n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_pix_ready: got %0b expected 1", pix_ready); end
    reset = 1'b0;
    tick();
    $display("test_reset_mid_burst: write=%0b idle=%0b", write, idle);
  endtask

  initial begin
    test_reset();
    test_merge();
    test_burst_stall();
    test_two_bursts();
    test_align_split();
    test_timeout();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
